// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, status codes, run-state
// encoding and condition-code bit positions. The execute stage builds
// new_cc using the same CC_* bit indices.
package y86_pkg;

    // Instruction codes
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // Register id meaning "no register"
    localparam logic [3:0] R_NONE   = 4'hF;

    // Status codes
    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd2;
    localparam logic [1:0] STAT_INS = 2'd3;

    // Processor run status
    typedef enum logic [1:0] {
        RS_RUN    = 2'd0,
        RS_HALTED = 2'd1,
        RS_FAULT  = 2'd2
    } run_state_t;

    // Condition-code bit indices within {OF,SF,ZF}
    localparam int CC_ZF = 0;
    localparam int CC_SF = 1;
    localparam int CC_OF = 2;

    // True for the two instructions that load a register from memory
    function automatic logic is_load(input logic [3:0] icode);
        return (icode == I_MRMOVQ) || (icode == I_POPQ);
    endfunction

    // True for a status under which the instruction still retires
    function automatic logic stat_retires(input logic [1:0] stat);
        return (stat == STAT_AOK) || (stat == STAT_HLT);
    endfunction

    // True for the statuses that end execution with an error
    function automatic logic stat_is_fault(input logic [1:0] stat);
        return (stat == STAT_ADR) || (stat == STAT_INS);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts enabled clocks and sticks at all-ones.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

    logic [WIDTH-1:0] count_reg;

    // Increment when enabled unless already at the ceiling
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (en && (count_reg != MAX)) begin
            count_reg <= count_reg + ONE;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pipe_control.sv
// Pipeline control for the five-stage Y86-64 core: stall/bubble generation
// for load-use, mispredicted-branch and ret hazards, the architectural
// condition-code register, run-status FSM and performance counters.
module pipe_control
    import y86_pkg::*;
#(
    parameter int         CNT_W    = 32,
    parameter logic [2:0] CC_RESET = 3'b001
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic             set_cc,
    input  logic [2:0]       new_cc,
    input  logic [3:0]       M_icode,
    input  logic [1:0]       m_stat,
    input  logic [3:0]       W_icode,
    input  logic [1:0]       W_stat,
    output logic [2:0]       cc,
    output logic             F_stall,
    output logic             D_stall,
    output logic             W_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic [1:0]       run_state,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    run_state_t state_reg;
    logic [2:0] cc_reg;

    logic load_use;
    logic ret_busy;
    logic mispred;
    logic exc;
    logic running;
    logic cc_write;
    logic cycle_en;
    logic instr_en;

    // Hazard detection, purely combinational so controls take effect this cycle
    always_comb begin
        load_use = is_load(E_icode) && (E_dstM != R_NONE) &&
                   ((E_dstM == d_srcA) || (E_dstM == d_srcB));
        ret_busy = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
        mispred  = (E_icode == I_JXX) && !e_Cnd;
        exc      = (m_stat != STAT_AOK) || (W_stat != STAT_AOK);
    end

    assign running = (state_reg == RS_RUN);

    // Stage controls; a stopped core freezes every stage and ignores hazards
    always_comb begin
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        W_stall  = 1'b0;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b0;
        if (reset) begin
            // hold everything quiet while reset is asserted
        end else if (!running) begin
            F_stall  = 1'b1;
            D_stall  = 1'b1;
            W_stall  = 1'b1;
            M_bubble = 1'b1;
        end else begin
            F_stall  = load_use | ret_busy;
            D_stall  = load_use;
            // a stalled decode register must keep its instruction, so stall wins
            D_bubble = mispred | (ret_busy & ~load_use);
            E_bubble = mispred | load_use;
            M_bubble = exc;
            W_stall  = (W_stat != STAT_AOK);
        end
    end

    // Run-status FSM: leave RUN on the status of the writeback instruction
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= RS_RUN;
        end else begin
            case (state_reg)
                RS_RUN: begin
                    if (W_stat == STAT_HLT) begin
                        state_reg <= RS_HALTED;
                    end else if (stat_is_fault(W_stat)) begin
                        state_reg <= RS_FAULT;
                    end
                end
                RS_HALTED: state_reg <= RS_HALTED;
                RS_FAULT:  state_reg <= RS_FAULT;
                default:   state_reg <= RS_FAULT;
            endcase
        end
    end

    // Only an OPq that is not shadowed by an exception may update the flags
    assign cc_write = set_cc && (E_icode == I_OPQ) && !exc && running;

    // Condition-code register; no bypass, readers see the update next cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cc_reg <= CC_RESET;
        end else if (cc_write) begin
            cc_reg <= new_cc;
        end
    end

    // Cycle counter covers every clock spent in RUN, including the exit clock
    assign cycle_en = running;

    // Retirement: valid non-bubble instruction leaving writeback, HALT included
    assign instr_en = running && stat_retires(W_stat) && (W_icode != I_NOP);

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_cycle_counter (
        .clock (clock),
        .reset (reset),
        .en    (cycle_en),
        .count (cycle_count)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_instr_counter (
        .clock (clock),
        .reset (reset),
        .en    (instr_en),
        .count (instr_count)
    );

    assign cc        = cc_reg;
    assign run_state = state_reg;

endmodule

// File: tb/tb_pipe_control.sv
// Scoreboard bench for pipe_control. A stimulus process drives one
// transaction per clock and pushes the reference model's expectation;
// a monitor on the falling edge pops and compares. A second instance with
// 4-bit counters shares the stimulus to exercise counter saturation.
module tb_pipe_control;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] D_icode = 4'h1, d_srcA = 4'hF, d_srcB = 4'hF;
    logic [3:0] E_icode = 4'h1, E_dstM = 4'hF;
    logic       e_Cnd = 1'b1, set_cc = 1'b0;
    logic [2:0] new_cc = 3'b000;
    logic [3:0] M_icode = 4'h1, W_icode = 4'h1;
    logic [1:0] m_stat = 2'd0, W_stat = 2'd0;

    logic [2:0]  cc;
    logic        F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble;
    logic [1:0]  run_state;
    logic [31:0] cycle_count, instr_count;

    logic [2:0]  x_cc;
    logic        x_F_stall, x_D_stall, x_W_stall, x_D_bubble, x_E_bubble, x_M_bubble;
    logic [1:0]  x_run_state;
    logic [3:0]  x_cycle_count, x_instr_count;

    pipe_control #(.CNT_W(32), .CC_RESET(3'b001)) dut (
        .clock(clock), .reset(reset),
        .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
        .set_cc(set_cc), .new_cc(new_cc),
        .M_icode(M_icode), .m_stat(m_stat),
        .W_icode(W_icode), .W_stat(W_stat),
        .cc(cc), .F_stall(F_stall), .D_stall(D_stall), .W_stall(W_stall),
        .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble),
        .run_state(run_state), .cycle_count(cycle_count), .instr_count(instr_count)
    );

    pipe_control #(.CNT_W(4), .CC_RESET(3'b001)) dut4 (
        .clock(clock), .reset(reset),
        .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
        .set_cc(set_cc), .new_cc(new_cc),
        .M_icode(M_icode), .m_stat(m_stat),
        .W_icode(W_icode), .W_stat(W_stat),
        .cc(x_cc), .F_stall(x_F_stall), .D_stall(x_D_stall), .W_stall(x_W_stall),
        .D_bubble(x_D_bubble), .E_bubble(x_E_bubble), .M_bubble(x_M_bubble),
        .run_state(x_run_state), .cycle_count(x_cycle_count), .instr_count(x_instr_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0] cc;
        logic       fs, ds, ws, db, eb, mb;
        logic [1:0] rs;
        longint     cyc, ins, cyc4;
    } exp_t;

    exp_t q[$];

    int total = 0;
    int bad   = 0;
    int txn   = 0;

    // Reference state: 0 RUN, 1 HALTED, 2 FAULT
    int         m_run = 0;
    logic [2:0] m_cc  = 3'b001;
    longint     m_cyc = 0;
    longint     m_ins = 0;

    task automatic check(input string name, input longint act, input longint want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (txn %0d)", name, act, want, txn);
        end
    endtask

    // One transaction: drive inputs just after the edge, record expectation,
    // then advance the reference model to what the next edge should produce.
    task automatic step(input bit rst, input logic [3:0] di, input logic [3:0] sa,
                        input logic [3:0] sb, input logic [3:0] ei, input logic [3:0] edm,
                        input bit cnd, input bit sc, input logic [2:0] nc,
                        input logic [3:0] mi, input logic [1:0] ms,
                        input logic [3:0] wi, input logic [1:0] ws);
        exp_t e;
        bit lu, rb, mp, ex;
        @(posedge clock);
        #1;
        reset = rst; D_icode = di; d_srcA = sa; d_srcB = sb;
        E_icode = ei; E_dstM = edm; e_Cnd = cnd; set_cc = sc; new_cc = nc;
        M_icode = mi; m_stat = ms; W_icode = wi; W_stat = ws;

        e = '{cc: 3'b001, fs: 0, ds: 0, ws: 0, db: 0, eb: 0, mb: 0, rs: 2'd0,
              cyc: 0, ins: 0, cyc4: 0};
        if (rst) begin
            m_run = 0; m_cc = 3'b001; m_cyc = 0; m_ins = 0;
            q.push_back(e);
        end else begin
            e.cc   = m_cc;
            e.rs   = 2'(m_run);
            e.cyc  = m_cyc;
            e.ins  = m_ins;
            e.cyc4 = (m_cyc > 15) ? 15 : m_cyc;
            lu = (ei inside {4'h5, 4'hB}) && (edm != 4'hF) && (edm == sa || edm == sb);
            rb = (di == 4'h9) || (ei == 4'h9) || (mi == 4'h9);
            mp = (ei == 4'h7) && !cnd;
            ex = (ms != 2'd0) || (ws != 2'd0);
            if (m_run != 0) begin
                e.fs = 1; e.ds = 1; e.ws = 1; e.mb = 1;
            end else begin
                e.fs = lu || rb;
                e.ds = lu;
                e.db = (mp || rb) && !lu;
                e.eb = mp || lu;
                e.mb = ex;
                e.ws = (ws != 2'd0);
            end
            q.push_back(e);
            if (m_run == 0) begin
                m_cyc++;
                if ((ws == 2'd0 || ws == 2'd1) && wi != 4'h1) m_ins++;
                if (sc && ei == 4'h6 && !ex) m_cc = nc;
                if (ws == 2'd1) m_run = 1;
                else if (ws >= 2'd2) m_run = 2;
            end
        end
    endtask

    task automatic idle();
        step(0, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1, 0, 3'b000, 4'h1, 2'd0, 4'h1, 2'd0);
    endtask

    function automatic logic [3:0] rnd_reg();
        return ($urandom_range(0, 5) == 5) ? 4'hF : 4'($urandom_range(0, 4));
    endfunction

    function automatic logic [1:0] rnd_stat(input int one_in);
        return ($urandom_range(1, one_in) == 1) ? 2'($urandom_range(1, 3)) : 2'd0;
    endfunction

    // Monitor: compare everything the DUT presents on the falling edge
    always @(negedge clock) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            txn++;
            check("cc",        cc,          e.cc);
            check("F_stall",   F_stall,     e.fs);
            check("D_stall",   D_stall,     e.ds);
            check("W_stall",   W_stall,     e.ws);
            check("D_bubble",  D_bubble,    e.db);
            check("E_bubble",  E_bubble,    e.eb);
            check("M_bubble",  M_bubble,    e.mb);
            check("run_state", run_state,   e.rs);
            check("cycle_cnt", cycle_count, e.cyc);
            check("instr_cnt", instr_count, e.ins);
            check("cycle_cnt4", x_cycle_count, e.cyc4);
            $display("txn %0d: rs=%0d cc=%b F=%0b D=%0b/%0b E=%0b M=%0b W=%0b cyc=%0d ins=%0d",
                     txn, run_state, cc, F_stall, D_stall, D_bubble, E_bubble,
                     M_bubble, W_stall, cycle_count, instr_count);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset
        step(1, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1, 0, 3'b000, 4'h1, 2'd0, 4'h1, 2'd0);
        idle();
        // Load-use, then cleared
        step(0, 4'h2, 4'h3, 4'h4, 4'h5, 4'h3, 1, 0, 3'b000, 4'h1, 2'd0, 4'h1, 2'd0);
        idle();
        // Mispredict, then taken
        step(0, 4'h2, 4'hF, 4'hF, 4'h7, 4'hF, 0, 0, 3'b000, 4'h1, 2'd0, 4'h1, 2'd0);
        step(0, 4'h2, 4'hF, 4'hF, 4'h7, 4'hF, 1, 0, 3'b000, 4'h1, 2'd0, 4'h1, 2'd0);
        // RET walking through D, E, M
        step(0, 4'h9, 4'h4, 4'hF, 4'h1, 4'hF, 1, 0, 3'b000, 4'h1, 2'd0, 4'h1, 2'd0);
        step(0, 4'h1, 4'hF, 4'hF, 4'h9, 4'hF, 1, 0, 3'b000, 4'h1, 2'd0, 4'h6, 2'd0);
        step(0, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1, 0, 3'b000, 4'h9, 2'd0, 4'h1, 2'd0);
        // RET in decode combined with load-use
        step(0, 4'h9, 4'h3, 4'hF, 4'h5, 4'h3, 1, 0, 3'b000, 4'h1, 2'd0, 4'h1, 2'd0);
        // CC gating
        step(0, 4'h1, 4'hF, 4'hF, 4'h6, 4'hF, 1, 1, 3'b010, 4'h1, 2'd0, 4'h1, 2'd0);
        idle();
        step(0, 4'h1, 4'hF, 4'hF, 4'h6, 4'hF, 1, 1, 3'b100, 4'h1, 2'd2, 4'h1, 2'd0);
        idle();
        step(0, 4'h1, 4'hF, 4'hF, 4'h2, 4'hF, 1, 1, 3'b111, 4'h1, 2'd0, 4'h1, 2'd0);
        idle();
        // Long RUN stretch so the 4-bit cycle counter saturates
        repeat (20) idle();
        // Halt, then hazards and CC writes while frozen
        step(0, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1, 0, 3'b000, 4'h1, 2'd0, 4'h0, 2'd1);
        step(0, 4'h9, 4'h3, 4'hF, 4'h5, 4'h3, 1, 1, 3'b110, 4'h1, 2'd0, 4'h6, 2'd0);
        step(0, 4'h1, 4'hF, 4'hF, 4'h6, 4'hF, 1, 1, 3'b110, 4'h1, 2'd0, 4'h6, 2'd0);
        idle();
        // Reset, write CC, then reset mid-stall
        step(1, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1, 0, 3'b000, 4'h1, 2'd0, 4'h1, 2'd0);
        step(0, 4'h1, 4'hF, 4'hF, 4'h6, 4'hF, 1, 1, 3'b110, 4'h1, 2'd0, 4'h1, 2'd0);
        step(0, 4'h2, 4'h3, 4'hF, 4'h5, 4'h3, 1, 0, 3'b000, 4'h1, 2'd0, 4'h1, 2'd0);
        step(1, 4'h2, 4'h3, 4'hF, 4'h5, 4'h3, 1, 0, 3'b000, 4'h1, 2'd0, 4'h1, 2'd0);
        // Fault run
        idle();
        idle();
        step(0, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1, 0, 3'b000, 4'h1, 2'd0, 4'h6, 2'd3);
        repeat (3) idle();

        // Randomized episodes, each starting from reset
        for (int ep = 0; ep < 8; ep++) begin
            step(1, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1, 0, 3'b000, 4'h1, 2'd0, 4'h1, 2'd0);
            for (int n = 0; n < 60; n++) begin
                step(0, 4'($urandom_range(0, 11)), rnd_reg(), rnd_reg(),
                     4'($urandom_range(0, 11)), rnd_reg(), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                     4'($urandom_range(0, 11)), rnd_stat(15),
                     4'($urandom_range(0, 11)), rnd_stat(40));
            end
        end

        repeat (3) @(posedge clock);
        check("queue_drain", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
